// File: rtl/sound_frame_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// sound_frame_scheduler_pkg
// Shared constants and types for the surround sound frame scheduler.
//   CLK_FREQ / SOUND_FREQ      : system clock and frame rate in Hz
//   SURROUND_CHANNELS          : default number of surround channels
//   SAMPLE_WIDTH               : default bits per sample
//   fetch_state_e              : frame-fetch FSM encoding
//   cycles_per_frame()         : strobe divider ratio (truncating)
// -----------------------------------------------------------------------------
package sound_frame_scheduler_pkg;

  localparam int CLK_FREQ          = 100_000_000;
  localparam int SOUND_FREQ        = 44_100;
  localparam int SURROUND_CHANNELS = 4;
  localparam int SAMPLE_WIDTH      = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } fetch_state_e;

  function automatic int cycles_per_frame(input int clk_in, input int clk_out);
    return clk_in / clk_out;
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// -----------------------------------------------------------------------------
// sample_tick_gen
// Divides the system clock down to a one-cycle frame strobe.
//   clkIn      in  : system clock (rising edge)
//   rstN       in  : asynchronous active-low reset
//   enable     in  : counts while high, holds while low
//   sampleTick out : registered strobe, high for one cycle at each wrap
// -----------------------------------------------------------------------------
module sample_tick_gen #(
  parameter int Cycles = 2267
) (
  input  logic clkIn,
  input  logic rstN,
  input  logic enable,
  output logic sampleTick
);

  localparam int CntW = (Cycles > 1) ? $clog2(Cycles) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Cycles - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (enable) begin
      if (cnt_q == LastCnt) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clkIn or negedge rstN) begin
    if (!rstN) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign sampleTick = tick_q;

endmodule

// File: rtl/sound_frame_scheduler.sv
// -----------------------------------------------------------------------------
// sound_frame_scheduler
// On each frame strobe, polls every surround channel's sample source in
// round-robin order and publishes one aligned multi-channel frame.
//   clkIn, rstN      in  : system clock, asynchronous active-low reset
//   enable           in  : runs the strobe divider
//   clearFlags       in  : clears the sticky underrun/overrun flags
//   sampleTick       out : one-cycle frame strobe
//   sampleReq        out : request to the sample source
//   sampleCh         out : channel index being requested
//   sampleAck        in  : sample source acknowledge
//   sampleData       in  : sample value, valid while sampleAck is high
//   frameData        out : published frame, channel 0 in the LSBs
//   frameValid       out : one-cycle pulse marking a new frame
//   underrun         out : sticky, a channel timed out
//   overrun          out : sticky, a strobe arrived mid-frame
//   stateDbg         out : current fetch FSM state (debug)
//
// Handshake: a sample transfers on a rising edge where sampleReq and
// sampleAck are both high. sampleReq stays high (with sampleCh updated)
// back-to-back across channels; sampleAck while sampleReq is low is ignored.
// -----------------------------------------------------------------------------
module sound_frame_scheduler
  import sound_frame_scheduler_pkg::*;
#(
  parameter int ClkInFreq   = CLK_FREQ,
  parameter int ClkOutFreq  = SOUND_FREQ,
  parameter int Channels    = SURROUND_CHANNELS,
  parameter int SampleWidth = SAMPLE_WIDTH,
  parameter int AckTimeout  = 8
) (
  input  logic                            clkIn,
  input  logic                            rstN,
  input  logic                            enable,
  input  logic                            clearFlags,
  output logic                            sampleTick,
  output logic                            sampleReq,
  output logic [$clog2(Channels)-1:0]     sampleCh,
  input  logic                            sampleAck,
  input  logic [SampleWidth-1:0]          sampleData,
  output logic [Channels*SampleWidth-1:0] frameData,
  output logic                            frameValid,
  output logic                            underrun,
  output logic                            overrun,
  output logic                            stateDbg
);

  localparam int Cycles = cycles_per_frame(ClkInFreq, ClkOutFreq);
  localparam int ChW    = $clog2(Channels);
  localparam int WaitW  = (AckTimeout > 1) ? $clog2(AckTimeout) : 1;
  localparam logic [ChW-1:0]   LastCh  = ChW'(Channels - 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(AckTimeout - 1);

  logic tick;

  sample_tick_gen #(
    .Cycles(Cycles)
  ) u_tick_gen (
    .clkIn     (clkIn),
    .rstN      (rstN),
    .enable    (enable),
    .sampleTick(tick)
  );

  fetch_state_e                  state_q, state_d;
  logic [ChW-1:0]                ch_q, ch_d;
  logic [WaitW-1:0]              wait_q, wait_d;
  logic [SampleWidth-1:0]        buf_q [Channels];
  logic [SampleWidth-1:0]        buf_d [Channels];
  logic [Channels*SampleWidth-1:0] frame_q, frame_d;
  logic                          valid_q, valid_d;
  logic                          under_q, under_d;
  logic                          over_q, over_d;
  logic                          under_set, over_set;
  logic                          xfer, tout;

  assign xfer = (state_q == ST_FETCH) && sampleAck;
  assign tout = (state_q == ST_FETCH) && !sampleAck && (wait_q == WaitMax);

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    wait_d    = wait_q;
    buf_d     = buf_q;
    frame_d   = frame_q;
    valid_d   = 1'b0;
    under_set = 1'b0;
    over_set  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          state_d = ST_FETCH;
          ch_d    = '0;
          wait_d  = '0;
        end
      end
      ST_FETCH: begin
        // A strobe mid-frame is dropped; the current frame carries on.
        if (tick) over_set = 1'b1;
        if (xfer || tout) begin
          // A timed-out channel contributes silence to the frame.
          buf_d[ch_q] = xfer ? sampleData : '0;
          wait_d      = '0;
          under_set   = tout;
          if (ch_q == LastCh) begin
            for (int i = 0; i < Channels; i++) begin
              frame_d[i*SampleWidth +: SampleWidth] = buf_d[i];
            end
            valid_d = 1'b1;
            state_d = ST_IDLE;
            ch_d    = '0;
          end else begin
            ch_d = ch_q + 1'b1;
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Set has priority over a simultaneous clear.
    under_d = (under_q && !clearFlags) || under_set;
    over_d  = (over_q && !clearFlags) || over_set;
  end

  always_ff @(posedge clkIn or negedge rstN) begin
    if (!rstN) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
      wait_q  <= '0;
      for (int i = 0; i < Channels; i++) buf_q[i] <= '0;
      frame_q <= '0;
      valid_q <= 1'b0;
      under_q <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      wait_q  <= wait_d;
      for (int i = 0; i < Channels; i++) buf_q[i] <= buf_d[i];
      frame_q <= frame_d;
      valid_q <= valid_d;
      under_q <= under_d;
      over_q  <= over_d;
    end
  end

  assign sampleTick = tick;
  assign sampleReq  = (state_q == ST_FETCH);
  assign sampleCh   = (state_q == ST_FETCH) ? ch_q : '0;
  assign frameData  = frame_q;
  assign frameValid = valid_q;
  assign underrun   = under_q;
  assign overrun    = over_q;
  assign stateDbg   = state_q;

endmodule

// File: tb/tb_sound_frame_scheduler.sv
// -----------------------------------------------------------------------------
// tb_sound_frame_scheduler
// Two instances: dut (1000 Hz / 10 Hz -> 100 cycles per frame) for the main
// scenarios and dut2 (1000 Hz / 50 Hz -> 20 cycles per frame) for overrun.
// Cycle n is the clock period following the n-th enabled rising edge; outputs
// are sampled and inputs driven 1 time unit after that edge.
// -----------------------------------------------------------------------------
module tb_sound_frame_scheduler;

  // ---------------- clock / reset ----------------
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstN, enable, clearFlags, sampleAck;
  logic [15:0] sampleData;
  logic        sampleTick, sampleReq, frameValid, underrun, overrun, stateDbg;
  logic [1:0]  sampleCh;
  logic [63:0] frameData;

  logic        rst2_n, en2, clr2, ack2;
  logic [15:0] data2;
  logic        tick2, req2, valid2, under2, over2, state2;
  logic [1:0]  ch2;
  logic [63:0] frame2;

  sound_frame_scheduler #(
    .ClkInFreq(1000), .ClkOutFreq(10), .Channels(4), .SampleWidth(16), .AckTimeout(8)
  ) dut (
    .clkIn(clk), .rstN(rstN), .enable(enable), .clearFlags(clearFlags),
    .sampleTick(sampleTick), .sampleReq(sampleReq), .sampleCh(sampleCh),
    .sampleAck(sampleAck), .sampleData(sampleData), .frameData(frameData),
    .frameValid(frameValid), .underrun(underrun), .overrun(overrun),
    .stateDbg(stateDbg)
  );

  sound_frame_scheduler #(
    .ClkInFreq(1000), .ClkOutFreq(50), .Channels(4), .SampleWidth(16), .AckTimeout(8)
  ) dut2 (
    .clkIn(clk), .rstN(rst2_n), .enable(en2), .clearFlags(clr2),
    .sampleTick(tick2), .sampleReq(req2), .sampleCh(ch2),
    .sampleAck(ack2), .sampleData(data2), .frameData(frame2),
    .frameValid(valid2), .underrun(under2), .overrun(over2),
    .stateDbg(state2)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int en_cnt = 0;

  logic [63:0] exp_q[$];
  int          exp_cyc_q[$];

  typedef struct {
    int         cyc;
    logic       tick;
    logic       req;
    logic [1:0] ch;
    logic       valid;
    logic       under;
  } vec_t;
  vec_t vec[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic add_row(input int c, input logic t, input logic r, input logic [1:0] ch,
                         input logic v, input logic u);
    vec_t row;
    row.cyc = c; row.tick = t; row.req = r; row.ch = ch; row.valid = v; row.under = u;
    vec.push_back(row);
  endtask

  // Frame the responder's pattern produces; a dropped channel reads as zero.
  function automatic logic [63:0] exp_frame(input int drop);
    logic [63:0] f;
    f = '0;
    for (int k = 0; k < 4; k++) begin
      if (k != drop) f[k*16 +: 16] = 16'(32'h1111 * (k + 1));
    end
    return f;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rstN = 1'b0; enable = 1'b0; clearFlags = 1'b0; sampleAck = 1'b0; sampleData = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sampleTick", sampleTick, 0);
    chk("rst_sampleReq",  sampleReq, 0);
    chk("rst_sampleCh",   sampleCh, 0);
    chk("rst_frameData",  frameData, 0);
    chk("rst_frameValid", frameValid, 0);
    chk("rst_underrun",   underrun, 0);
    chk("rst_overrun",    overrun, 0);
    rstN = 1'b1; enable = 1'b1;
    cyc = 0; en_cnt = 0;
    exp_q.delete(); exp_cyc_q.delete(); vec.delete();
  endtask

  // Runs dut up to cycle n. The responder acks every channel immediately
  // except channel 'drop', which is never acked.
  task automatic run(input int n, input int drop, input int dis_at, input int dis_len,
                     input int clear_at);
    logic exp_tick;
    int   c;
    while (cyc < n) begin
      @(posedge clk);
      exp_tick = 1'b0;
      if (enable) begin
        en_cnt++;
        exp_tick = (en_cnt % 100 == 0);
      end
      cyc++;
      #1;
      chk("sampleTick", sampleTick, exp_tick);
      if (exp_tick) begin
        exp_q.push_back(exp_frame(drop));
        exp_cyc_q.push_back(cyc + 5 + ((drop >= 0) ? 7 : 0));
      end
      for (int i = 0; i < vec.size(); i++) begin
        if (vec[i].cyc == cyc) begin
          chk("row_tick",  sampleTick, vec[i].tick);
          chk("row_req",   sampleReq,  vec[i].req);
          chk("row_ch",    sampleCh,   vec[i].ch);
          chk("row_valid", frameValid, vec[i].valid);
          chk("row_under", underrun,   vec[i].under);
        end
      end
      if (frameValid) begin
        chk("frame_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          chk("frameData", frameData, exp_q.pop_front());
          chk("frame_cycle", cyc, exp_cyc_q.pop_front());
        end
      end
      if (cyc == dis_at) enable = 1'b0;
      if (cyc == dis_at + dis_len) enable = 1'b1;
      clearFlags = (cyc == clear_at);
      if (sampleReq && int'(sampleCh) != drop) begin
        sampleAck  = 1'b1;
        c          = int'(sampleCh);
        sampleData = 16'(32'h1111 * (c + 1));
      end else begin
        sampleAck  = 1'b0;
        sampleData = 16'($urandom);
      end
    end
  endtask

  task automatic frames_done();
    chk("frames_pending", exp_q.size(), 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst2_n = 1'b0; en2 = 1'b0; clr2 = 1'b0; ack2 = 1'b0; data2 = '0;

    // Strobe period, continuous enable.
    do_reset();
    run(310, -1, -1, 0, -1);
    frames_done();

    // Enable dropped at 150 for 50 cycles: next strobe at 250.
    do_reset();
    run(260, -1, 150, 50, -1);
    frames_done();

    // Immediate acks.
    do_reset();
    add_row(100, 1, 0, 2'd0, 0, 0);
    add_row(101, 0, 1, 2'd0, 0, 0);
    add_row(102, 0, 1, 2'd1, 0, 0);
    add_row(103, 0, 1, 2'd2, 0, 0);
    add_row(104, 0, 1, 2'd3, 0, 0);
    add_row(105, 0, 0, 2'd0, 1, 0);
    add_row(106, 0, 0, 2'd0, 0, 0);
    run(110, -1, -1, 0, -1);
    frames_done();

    // Ack with no request in IDLE is ignored.
    sampleAck = 1'b1;
    sampleData = 16'hDEAD;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      cyc++;
      #1;
      chk("noreq_frameData", frameData, 64'h4444_3333_2222_1111);
      chk("noreq_frameValid", frameValid, 0);
      chk("noreq_underrun", underrun, 0);
      chk("noreq_overrun", overrun, 0);
    end
    sampleAck = 1'b0;

    // ch2 never acks: timeout, underrun, then clearFlags.
    do_reset();
    add_row(101, 0, 1, 2'd0, 0, 0);
    add_row(103, 0, 1, 2'd2, 0, 0);
    add_row(110, 0, 1, 2'd2, 0, 0);
    add_row(111, 0, 1, 2'd3, 0, 1);
    add_row(112, 0, 0, 2'd0, 1, 1);
    add_row(113, 0, 0, 2'd0, 0, 1);
    add_row(114, 0, 0, 2'd0, 0, 0);
    run(115, 2, -1, 0, 113);
    frames_done();

    // ch3 times out on the same edge clearFlags is applied: set wins.
    do_reset();
    add_row(111, 0, 1, 2'd3, 0, 0);
    add_row(112, 0, 0, 2'd0, 1, 1);
    add_row(113, 0, 0, 2'd0, 0, 1);
    run(115, 3, -1, 0, 111);
    frames_done();

    // Reset mid-frame during the ch1 request (ch0 timed out first).
    do_reset();
    run(109, 0, -1, 0, -1);
    chk("pre_rst_req", sampleReq, 1);
    chk("pre_rst_ch", sampleCh, 1);
    chk("pre_rst_under", underrun, 1);
    rstN = 1'b0;
    #1;
    chk("midrst_req", sampleReq, 0);
    chk("midrst_valid", frameValid, 0);
    chk("midrst_under", underrun, 0);
    chk("midrst_over", overrun, 0);
    chk("midrst_frameData", frameData, 0);
    sampleAck = 1'b0;
    #2;
    rstN = 1'b1;
    cyc = 0; en_cnt = 0;
    exp_q.delete(); exp_cyc_q.delete();
    run(110, -1, -1, 0, -1);
    frames_done();

    // Overrun on dut2: 20-cycle strobe, no acks, 33-cycle frames.
    @(posedge clk);
    #1;
    rst2_n = 1'b1;
    en2 = 1'b1;
    for (int c2 = 1; c2 <= 75; c2++) begin
      @(posedge clk);
      #1;
      cyc = c2;
      case (c2)
        20: chk("ovr_tick20", tick2, 1);
        21: begin chk("ovr_req21", req2, 1); chk("ovr_ch21", ch2, 0); end
        39: chk("ovr_over39", over2, 0);
        40: begin chk("ovr_tick40", tick2, 1); chk("ovr_req40", req2, 1); end
        41: begin chk("ovr_over41", over2, 1); chk("ovr_under41", under2, 1); end
        52: begin chk("ovr_req52", req2, 1); chk("ovr_ch52", ch2, 3); end
        53: begin
          chk("ovr_valid53", valid2, 1);
          chk("ovr_req53", req2, 0);
          chk("ovr_frame53", frame2, 0);
        end
        54: chk("ovr_valid54", valid2, 0);
        60: begin chk("ovr_tick60", tick2, 1); chk("ovr_req60", req2, 0); end
        61: begin chk("ovr_req61", req2, 1); chk("ovr_ch61", ch2, 0); end
        66: begin chk("ovr_over66", over2, 0); chk("ovr_under66", under2, 0); end
        default: ;
      endcase
      clr2 = (c2 == 65);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sound_frame_scheduler.md
# sound_frame_scheduler

Sequences per-sample channel fetches for the surround sound output path. It derives a one-cycle sample strobe at `SoundFreq` from the system clock. On each strobe it polls every surround channel's sample source in round-robin order over a req/ack handshake, then publishes one aligned multi-channel frame. It sits between the per-channel sample sources and the DAC/serializer stage, and replaces free-running divided sound clocks with a single synchronous strobe.

## Interface
- `ClkInFreq`, default `` `ClkFreq ``: input clock frequency in Hz.
- `ClkOutFreq`, default `` `SoundFreq ``: frame rate in Hz.
- `Channels`, default 4: number of surround channels; must be ≥ 2.
- `SampleWidth`, default 16: bits per sample.
- `AckTimeout`, default 8: maximum number of cycles to wait for an ack per channel.
- `clkIn` in 1: system clock; all logic runs on its rising edge.
- `rstN` in 1: asynchronous, active-low reset.
- `enable` in 1: runs the strobe divider.
- `clearFlags` in 1: clears the sticky flags.
- `sampleTick` out 1: one-cycle frame strobe.
- `sampleReq` out 1: request to the sample source.
- `sampleCh` out clog2(Channels): index of the channel being requested.
- `sampleAck` in 1: sample source acknowledge.
- `sampleData` in SampleWidth: sample value, valid while `sampleAck` is high.
- `frameData` out Channels*SampleWidth: published frame; channel 0 occupies the LSBs.
- `frameValid` out 1: one-cycle pulse indicating a new frame on `frameData`.
- `underrun` out 1: sticky flag; a channel timed out.
- `overrun` out 1: sticky flag; a strobe arrived while a frame was still in progress.

## Operation
- Cycles = ClkInFreq / ClkOutFreq, integer truncation. Example: 100 MHz / 44100 = 2267.
- Divider counter:
  - Width is clog2(Cycles).
  - Counts 0..Cycles-1 while `enable` is high, then wraps to 0.
  - `sampleTick` is registered and high for exactly one cycle at each wrap.
  - While `enable` is low, the counter holds its value and no strobe is generated.
- FSM states are IDLE and FETCH.
  - IDLE with `sampleTick` high: go to FETCH with ch=0 and waitCnt=0.
  - FETCH: `sampleReq`=1 and `sampleCh`=ch.
  - Transfer: `sampleReq` and `sampleAck` both high at a rising edge. On that edge, buffer[ch] is loaded with `sampleData` and waitCnt is reset to 0.
  - Timeout: waitCnt reaches AckTimeout-1 with no ack. On that edge, buffer[ch] is loaded with 0 and `underrun` is set.
  - Advance (transfer or timeout) with ch < Channels-1: ch increments, the FSM stays in FETCH, and requests continue back-to-back.
  - Advance on ch = Channels-1: `frameData` is loaded from the buffer (using `sampleData` for the last channel), `frameValid` is set, and the FSM returns to IDLE.
- `sampleTick` high while the FSM is in FETCH: `overrun` is set and the strobe is dropped; the current frame continues.
- If `enable` is deasserted mid-frame, the current frame still completes.
- `clearFlags` clears `underrun` and `overrun`. If a clear and a set occur in the same cycle, the set wins.
- `frameData` holds its value between frames.

## Timing
- Reset values: every output is 0, the counter is 0, the FSM is in IDLE, and the buffer is 0.
- Reset assertion takes effect asynchronously, including mid-frame. The first strobe after release arrives Cycles enabled cycles later.
- With the first enabled edge as cycle 1, `sampleTick` is high in cycle Cycles and every Cycles cycles after that.
- Strobe in cycle T: `sampleReq` is high from cycle T+1.
- With ack in the same cycle as the request, channel k is requested in cycle T+1+k, and `frameValid` is high in cycle T+Channels+1 for one cycle.
- Worst-case frame length is Channels*AckTimeout+1 cycles. If Cycles ≤ that value, an overrun is expected and the design does not prevent it.
- `sampleAck` while `sampleReq` is low is ignored.

## Structure
- `src/parameters.v` supplies `ClkFreq` and `SoundFreq`. Add `` `SurroundChannels `` and `` `SampleWidth `` there so the defaults come from the shared file.
- Sub-module `sample_tick_gen`: divider plus registered strobe, with ports clkIn, rstN, enable, sampleTick.
- The FSM, buffer and flags live in the top module.

## Test plan
All scenarios use ClkInFreq=1000, ClkOutFreq=10 (Cycles=100), Channels=4, SampleWidth=16, AckTimeout=8 unless stated.
- Strobe period: reset, then hold enable=1 → sampleTick is high only in cycles 100, 200 and 300; deassert enable at 150 for 50 cycles → the next strobe arrives at 250.
- Immediate acks with sampleData=0x1111*(ch+1) → sampleCh steps 0..3 in cycles 101..104; frameValid is high only in cycle 105; frameData=0x4444_3333_2222_1111.
- No ack on ch2, others immediate → ch2 times out after 8 cycles; frameData ch2=0; underrun=1; frameValid in cycle 112; clearFlags drops underrun.
- Overrun: Cycles=20, no acks at all → a frame takes 33 cycles; the strobe at 40 sets overrun; the next frame starts only on the strobe at 60.
- Reset mid-frame: rstN low during the ch1 request → sampleReq, frameValid and flags are 0 immediately; after release, the first strobe is 100 cycles later and frameData=0.
- Ack with no request: drive sampleAck=1 in IDLE → buffer, frameData and flags are unchanged.
